// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and default sizes for the I/D cache to line-BRAM arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY, RELEASE)
//   owner_t : which cache owns the current BRAM transaction
//   DEF_LINE_WIDTH / DEF_MEM_ADDR_BITS : default line and line-address widths
// ---------------------------------------------------------------------------
package cache_arb_pkg;

   localparam int DEF_LINE_WIDTH    = 128;
   localparam int DEF_MEM_ADDR_BITS = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_D = 1'b0,
      OWN_I = 1'b1
   } owner_t;

endpackage

// File: rtl/cache_bram_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_bram_arbiter_if
// Bundles the I-cache port, D-cache port and BRAM port of the arbiter.
//   slave  : arbiter view (cache requests and BRAM completion are inputs;
//            valid pulses, shared rdata, err and mem_* bus are outputs)
//   master : environment view (caches + BRAM), directions reversed
// Parameters: MEM_ADDR_BITS (line address width), LINE_WIDTH (line width).
// ---------------------------------------------------------------------------
interface cache_bram_arbiter_if
   import cache_arb_pkg::*;
#(
   parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
   parameter int LINE_WIDTH    = DEF_LINE_WIDTH
);

   // I-cache side
   logic                     i_req;
   logic                     i_write;
   logic [MEM_ADDR_BITS-1:0] i_addr;
   logic [LINE_WIDTH-1:0]    i_wdata;
   logic                     i_valid;

   // D-cache side
   logic                     d_req;
   logic                     d_write;
   logic [MEM_ADDR_BITS-1:0] d_addr;
   logic [LINE_WIDTH-1:0]    d_wdata;
   logic                     d_valid;

   // shared completion data
   logic [LINE_WIDTH-1:0]    rdata;
   logic                     err;

   // BRAM side
   logic                     mem_req;
   logic                     mem_write;
   logic [MEM_ADDR_BITS-1:0] mem_addr;
   logic [LINE_WIDTH-1:0]    mem_wdata;
   logic [LINE_WIDTH-1:0]    mem_rdata;
   logic                     mem_valid;

   modport slave (
      input  i_req, i_write, i_addr, i_wdata,
      input  d_req, d_write, d_addr, d_wdata,
      input  mem_rdata, mem_valid,
      output i_valid, d_valid, rdata, err,
      output mem_req, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_write, i_addr, i_wdata,
      output d_req, d_write, d_addr, d_wdata,
      output mem_rdata, mem_valid,
      input  i_valid, d_valid, rdata, err,
      input  mem_req, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/cache_arb_timeout.sv
// ---------------------------------------------------------------------------
// cache_arb_timeout
// Up counter that measures how long a BRAM transaction has been outstanding.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart counting from 0 (takes priority over en)
//   en         : count this cycle
//   expire     : high while enabled and the count has reached LIMIT-1
// Parameter LIMIT: number of enabled cycles in one timeout window (>= 2).
// ---------------------------------------------------------------------------
module cache_arb_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CW'(1);
      end
   end

   // Gated by en so a stale count outside a transaction never fires.
   assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/cache_bram_arbiter.sv
// ---------------------------------------------------------------------------
// cache_bram_arbiter
// Serialises I-cache and D-cache line refills/writebacks onto one line BRAM.
// One transaction at a time, D wins ties, every transaction is bounded by a
// timeout, and each cache gets a single-cycle registered valid pulse.
//
// Ports:
//   HCLK     : clock
//   HRESETn  : synchronous active-low reset
//   bus      : cache_bram_arbiter_if.slave
//              i_* / d_* request ports, i_valid / d_valid pulses,
//              shared rdata + err, mem_* BRAM request/response
//
// Parameters: MEM_ADDR_BITS, LINE_WIDTH, TIMEOUT_CYCLES (>= 2),
//             MAX_D_STREAK (only with CACHE_ARB_FAIRNESS_EN).
//
// Build option: define CACHE_ARB_FAIRNESS_EN to let the I port win a tie
// after MAX_D_STREAK consecutive contested D grants. Without it every tie
// goes to D.
// ---------------------------------------------------------------------------
module cache_bram_arbiter
   import cache_arb_pkg::*;
#(
   parameter int MEM_ADDR_BITS  = DEF_MEM_ADDR_BITS,
   parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_D_STREAK   = 4
) (
   input logic                  HCLK,
   input logic                  HRESETn,
   cache_bram_arbiter_if.slave  bus
);

   state_t                   state_q, state_d;
   owner_t                   owner_q, owner_d;
   logic                     mem_req_q, mem_req_d;
   logic                     mem_write_q, mem_write_d;
   logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic [LINE_WIDTH-1:0]    rdata_q, rdata_d;
   logic                     i_valid_q, i_valid_d;
   logic                     d_valid_q, d_valid_d;
   logic                     err_q, err_d;

   logic                     tmo_clr, tmo_en, tmo_expire;
   logic                     any_req, grant_i, i_turn;

   // ------------------------------------------------------------------
   // Tie-break: i_turn says the I port wins a contested grant.
   // ------------------------------------------------------------------
`ifdef CACHE_ARB_FAIRNESS_EN
   localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

   logic [SW-1:0] streak_q, streak_d;

   assign i_turn = (streak_q == SW'(MAX_D_STREAK));
`else
   logic [31:0] unused_streak_cfg;

   assign unused_streak_cfg = 32'(MAX_D_STREAK);
   assign i_turn            = 1'b0;
`endif

   assign any_req = bus.i_req || bus.d_req;
   assign grant_i = bus.i_req && (!bus.d_req || i_turn);

   cache_arb_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (HCLK),
      .rst_n  (HRESETn),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         owner_q     <= OWN_D;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         i_valid_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         err_q       <= 1'b0;
`ifdef CACHE_ARB_FAIRNESS_EN
         streak_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         i_valid_q   <= i_valid_d;
         d_valid_q   <= d_valid_d;
         err_q       <= err_d;
`ifdef CACHE_ARB_FAIRNESS_EN
         streak_q    <= streak_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next state / next outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      i_valid_d   = 1'b0;        // valid/err are single-cycle pulses
      d_valid_d   = 1'b0;
      err_d       = 1'b0;
      tmo_clr     = 1'b0;
      tmo_en      = 1'b0;
`ifdef CACHE_ARB_FAIRNESS_EN
      streak_d    = streak_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d     = grant_i ? OWN_I : OWN_D;
               mem_req_d   = 1'b1;
               mem_write_d = grant_i ? bus.i_write : bus.d_write;
               mem_addr_d  = grant_i ? bus.i_addr  : bus.d_addr;
               mem_wdata_d = grant_i ? bus.i_wdata : bus.d_wdata;
               tmo_clr     = 1'b1;
               state_d     = BUSY;
`ifdef CACHE_ARB_FAIRNESS_EN
               // Only D grants that beat a waiting I count towards the streak.
               if (grant_i) begin
                  streak_d = '0;
               end else if (bus.i_req && !i_turn) begin
                  streak_d = streak_q + SW'(1);
               end
`endif
            end
         end

         BUSY: begin
            // Requests are not looked at here; mem_* stays frozen.
            tmo_en = 1'b1;
            if (bus.mem_valid || tmo_expire) begin
               mem_req_d   = 1'b0;
               mem_write_d = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               if (owner_q == OWN_I) begin
                  i_valid_d = 1'b1;
               end else begin
                  d_valid_d = 1'b1;
               end
               // A real completion beats a timeout landing the same cycle.
               if (bus.mem_valid) begin
                  if (!mem_write_q) begin
                     rdata_d = bus.mem_rdata;
                  end
               end else begin
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            // One dead cycle lets the served cache drop its request.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rdata     = rdata_q;
   assign bus.i_valid   = i_valid_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.err       = err_q;

endmodule
